// File: rtl/sw_conditioner.sv
// Slide-switch conditioner: per-bit 2-flop synchronizer, debounce counter and edge pulses.
// Optional SW_COND_STICKY_EN adds clr_chg / chg_flags sticky "switch moved" flags.

module sw_cond_bit #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o,
    output logic pending_o
);
    localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Any cycle where the synced level matches the accepted level restarts the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync_i != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = sync_i;
                rise_d   = sync_i;
                fall_d   = ~sync_i;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o  = stable_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign pending_o = sync_i ^ stable_q;
endmodule

module sw_conditioner #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_settled
`ifdef SW_COND_STICKY_EN
    ,
    input  logic             clr_chg,
    output logic [WIDTH-1:0] chg_flags
`endif
);
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        sw_cond_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .sync_i   (sync2_q[g]),
            .stable_o (sw_out[g]),
            .rise_o   (sw_rise[g]),
            .fall_o   (sw_fall[g]),
            .pending_o(pending[g])
        );
    end

    assign sw_settled = ~|pending;

`ifdef SW_COND_STICKY_EN
    logic [WIDTH-1:0] chg_q, chg_d;

    // A pulse arriving in the same cycle as a clear still leaves its flag set.
    always_comb begin
        chg_d = (chg_q & ~{WIDTH{clr_chg}}) | sw_rise | sw_fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chg_q <= '0;
        else        chg_q <= chg_d;
    end

    assign chg_flags = chg_q;
`endif
endmodule

// File: tb/tb_sw_conditioner.sv
// Self-checking bench for sw_conditioner (DEBOUNCE_CYCLES=4): directed scenarios plus
// randomized switch activity compared against a run-length behavioural model.
module tb_sw_conditioner;
    localparam int W  = 10;
    localparam int DC = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_out, sw_rise, sw_fall;
    logic         sw_settled;
`ifdef SW_COND_STICKY_EN
    logic         clr_chg = 1'b0;
    logic [W-1:0] chg_flags;
`endif

    int n_vec = 0;
    int n_err = 0;

    sw_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .sw_out    (sw_out),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_settled(sw_settled)
`ifdef SW_COND_STICKY_EN
        ,
        .clr_chg   (clr_chg),
        .chg_flags (chg_flags)
`endif
    );

    always #5 clk = ~clk;

    // Model: two-sample delay line, then a level is accepted once the delayed input
    // has disagreed with the accepted level on DC consecutive edges.
    logic [W-1:0] m_s1, m_s2, m_st, m_rise, m_fall, m_chg;
    int           m_run [W];
    logic [W-1:0] t_st, t_r, t_f;
    int           t_run [W];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= '0; m_s2 <= '0; m_st <= '0;
            m_rise <= '0; m_fall <= '0; m_chg <= '0;
            m_run <= '{default: 0};
        end else begin
            t_st = m_st; t_r = '0; t_f = '0; t_run = m_run;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] !== m_st[i]) begin
                    t_run[i] = t_run[i] + 1;
                    if (t_run[i] == DC) begin
                        t_st[i] = m_s2[i];
                        t_r[i]  = m_s2[i];
                        t_f[i]  = !m_s2[i];
                        t_run[i] = 0;
                    end
                end else begin
                    t_run[i] = 0;
                end
            end
`ifdef SW_COND_STICKY_EN
            m_chg <= (m_chg & ~{W{clr_chg}}) | m_rise | m_fall;
`endif
            m_st <= t_st; m_rise <= t_r; m_fall <= t_f; m_run <= t_run;
            m_s2 <= m_s1; m_s1 <= sw_raw;
        end
    end

    task automatic test_reset();
        logic [W-1:0] e_out, e_rise;
        logic         e_set;
        rst_n = 1'b0; sw_raw = 10'h3FF;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({sw_out, sw_rise, sw_fall, sw_settled} !== {30'h0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state out=%h rise=%h fall=%h settled=%b want 000/000/000/1",
                     sw_out, sw_rise, sw_fall, sw_settled);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            e_out  = (e >= 6) ? 10'h3FF : 10'h000;
            e_rise = (e == 6) ? 10'h3FF : 10'h000;
            e_set  = (e == 1) || (e >= 6);
            n_vec++;
            if (sw_out !== e_out || sw_rise !== e_rise || sw_fall !== '0 || sw_settled !== e_set) begin
                n_err++;
                $display("FAIL held_through_reset e%0d out=%h/%h rise=%h/%h fall=%h settled=%b/%b",
                         e, sw_out, e_out, sw_rise, e_rise, sw_fall, sw_settled, e_set);
            end
        end
    endtask

    task automatic test_settle(input logic [W-1:0] val);
        sw_raw = val;
        for (int c = 0; c < DC + 6; c++) begin
            @(negedge clk);
            n_vec++;
            if (sw_out !== m_st || sw_rise !== m_rise || sw_fall !== m_fall ||
                sw_settled !== (m_s2 == m_st)) begin
                n_err++;
                $display("FAIL settle c%0d out=%h/%h rise=%h/%h fall=%h/%h settled=%b/%b",
                         c, sw_out, m_st, sw_rise, m_rise, sw_fall, m_fall, sw_settled, m_s2 == m_st);
            end
        end
    endtask

    task automatic test_single_rise();
        logic [W-1:0] e_out, e_rise;
        test_settle(10'h000);
        sw_raw = 10'h001;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            e_out  = (e >= 6) ? 10'h001 : 10'h000;
            e_rise = (e == 6) ? 10'h001 : 10'h000;
            n_vec++;
            if (sw_out !== e_out || sw_rise !== e_rise || sw_fall !== '0) begin
                n_err++;
                $display("FAIL single_rise e%0d out=%h/%h rise=%h/%h fall=%h/000",
                         e, sw_out, e_out, sw_rise, e_rise, sw_fall);
            end
        end
    endtask

    task automatic test_bounce();
        logic [W-1:0] pat;
        pat = 10'h001;
        for (int c = 0; c < 14; c++) begin
            sw_raw = (c < 4) ? (pat | ((c % 2 == 0) ? 10'h008 : 10'h000)) : pat;
            @(negedge clk);
            n_vec++;
            if (sw_out !== 10'h001 || sw_rise !== '0 || sw_fall !== '0) begin
                n_err++;
                $display("FAIL bounce c%0d out=%h/001 rise=%h fall=%h", c, sw_out, sw_rise, sw_fall);
            end
        end
        n_vec++;
        if (sw_settled !== 1'b1) begin
            n_err++;
            $display("FAIL bounce_settled got=%b want=1", sw_settled);
        end
    endtask

    task automatic test_two_bit_fall();
        logic [W-1:0] e_out, e_fall;
        test_settle(10'h205);
        sw_raw = 10'h001;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            e_out  = (e >= 6) ? 10'h001 : 10'h205;
            e_fall = (e == 6) ? 10'h204 : 10'h000;
            n_vec++;
            if (sw_out !== e_out || sw_fall !== e_fall || sw_rise !== '0) begin
                n_err++;
                $display("FAIL two_bit_fall e%0d out=%h/%h fall=%h/%h rise=%h",
                         e, sw_out, e_out, sw_fall, e_fall, sw_rise);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [W-1:0] e_out, e_rise;
        sw_raw = 10'h021;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (sw_out !== '0 || sw_rise !== '0 || sw_fall !== '0) begin
            n_err++;
            $display("FAIL mid_count_reset out=%h rise=%h fall=%h want 000", sw_out, sw_rise, sw_fall);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            e_out  = (e >= 6) ? 10'h021 : 10'h000;
            e_rise = (e == 6) ? 10'h021 : 10'h000;
            n_vec++;
            if (sw_out !== e_out || sw_rise !== e_rise || sw_fall !== '0) begin
                n_err++;
                $display("FAIL after_mid_reset e%0d out=%h/%h rise=%h/%h fall=%h",
                         e, sw_out, e_out, sw_rise, e_rise, sw_fall);
            end
        end
    endtask

`ifdef SW_COND_STICKY_EN
    task automatic test_sticky();
        clr_chg = 1'b1;
        test_settle(10'h021);
        sw_raw = 10'h023;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            n_vec++;
            if (chg_flags !== m_chg) begin
                n_err++;
                $display("FAIL sticky_model e%0d chg=%h want=%h", e, chg_flags, m_chg);
            end
            if (e == 7) begin
                n_vec++;
                if (chg_flags !== 10'h002) begin
                    n_err++;
                    $display("FAIL sticky_set_wins chg=%h want=002", chg_flags);
                end
            end
            if (e == 8) begin
                n_vec++;
                if (chg_flags !== 10'h000) begin
                    n_err++;
                    $display("FAIL sticky_clear chg=%h want=000", chg_flags);
                end
            end
        end
        clr_chg = 1'b0;
    endtask
`endif

    task automatic test_random();
        int hold;
        hold = 0;
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                sw_raw = sw_raw ^ (W'($urandom) & W'($urandom));
                hold   = $urandom_range(1, 2 * DC + 2);
            end
            hold--;
`ifdef SW_COND_STICKY_EN
            clr_chg = ($urandom_range(0, 7) == 0);
`endif
            @(negedge clk);
            n_vec++;
            if (sw_out !== m_st || sw_rise !== m_rise || sw_fall !== m_fall ||
                sw_settled !== (m_s2 == m_st)) begin
                n_err++;
                $display("FAIL random c%0d out=%h/%h rise=%h/%h fall=%h/%h settled=%b/%b",
                         c, sw_out, m_st, sw_rise, m_rise, sw_fall, m_fall, sw_settled, m_s2 == m_st);
            end
`ifdef SW_COND_STICKY_EN
            n_vec++;
            if (chg_flags !== m_chg) begin
                n_err++;
                $display("FAIL random_chg c%0d chg=%h want=%h", c, chg_flags, m_chg);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_bounce();
        test_two_bit_fall();
        test_reset_mid_count();
`ifdef SW_COND_STICKY_EN
        test_sticky();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
